alu_div32: RTL

Sequential 32-bit signed integer divider for the phase-1 ALU. It is the division counterpart to the 32-bit Booth multiplier and shares its 64-bit result convention: the upper half goes to HI and the lower half to LO. The block accepts a dividend/divisor pair on a start pulse and computes one quotient bit per clock using restoring division on magnitudes. It applies sign correction at the end and presents {remainder, quotient} with a one-cycle done pulse.

---
 rtl/alu_div32.sv | 100 ++++++++++
 1 files changed

// File: rtl/alu_div32.sv
// Sequential 32-bit signed divider: restoring division on magnitudes, one quotient
// bit per clock, sign fix-up at the end, result packed as {remainder, quotient}.
module alu_div32 (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIX} state_t;

  state_t      state;
  logic        sa;
  logic        sb;
  logic        b_zero;
  logic [31:0] q;
  logic [32:0] d;
  logic [31:0] r;
  logic [4:0]  count;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] r_shift;
  logic [32:0] diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] zero_rem;

  // The partial remainder always stays below the divisor, so 32 stored bits
  // are enough; the shifted/trial values carry the extra sign bit.
  always_comb begin
    abs_a    = a[31] ? -a : a;
    abs_b    = b[31] ? -b : b;
    r_shift  = {r, q[31]};
    diff     = r_shift - d;
    quo_fix  = (sa ^ sb) ? -q : q;
    rem_fix  = sa ? -r : r;
    zero_rem = sa ? -q : q;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      sa       <= 1'b0;
      sb       <= 1'b0;
      b_zero   <= 1'b0;
      q        <= '0;
      d        <= '0;
      r        <= '0;
      count    <= '0;
      p        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a[31];
            sb     <= b[31];
            q      <= abs_a;
            d      <= {1'b0, abs_b};
            r      <= '0;
            count  <= '0;
            b_zero <= (b == 32'h0);
            busy   <= 1'b1;
            state  <= (b == 32'h0) ? FIX : DIVIDE;
          end
        end
        DIVIDE: begin
          if (!diff[32]) begin
            r <= diff[31:0];
            q <= {q[30:0], 1'b1};
          end else begin
            r <= r_shift[31:0];
            q <= {q[30:0], 1'b0};
          end
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIX;
        end
        FIX: begin
          // On divide by zero Q still holds |a|, so re-signing it restores a.
          p        <= b_zero ? {zero_rem, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
          done     <= 1'b1;
          div_zero <= b_zero;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
